// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter.
// Owner encodings track which requester the in-flight access belongs to.
package imem_arb_pkg;

  localparam int c_ADDR_W = 8;
  localparam int c_DATA_W = 8;

  typedef enum logic [1:0] {
    s_NONE  = 2'd0,
    s_CPU   = 2'd1,
    s_LD_RD = 2'd2,
    s_LD_WR = 2'd3
  } owner_e;

endpackage

// File: rtl/imem_port_arbiter.sv
// Single-port IMEM arbiter between CPU fetch and program loader.
// IMEM_ARB_ROUND_ROBIN_EN: alternate grants instead of burst-limited loader priority.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W         = c_ADDR_W,
  parameter int DATA_W         = c_DATA_W,
  parameter int MAX_LOAD_BURST = 4
) (
  input  logic              Clk,
  input  logic              CLB,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic              FetchValid,
  output logic [DATA_W-1:0] FetchData,
  output logic              Stall,
  input  logic              LoadReq,
  input  logic              LoadWe,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadWData,
  output logic              LoadGnt,
  output logic              LoadValid,
  output logic [DATA_W-1:0] LoadRData,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  logic cpu_gnt;
  logic ld_gnt;

  owner_e owner_q, owner_d;

  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_W-1:0] load_rdata_q, load_rdata_d;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  // last_cpu_q resets to 0 so the first contended grant goes to the CPU
  logic last_cpu_q, last_cpu_d;

  always_comb begin
    cpu_gnt    = 1'b0;
    ld_gnt     = 1'b0;
    last_cpu_d = last_cpu_q;
    if (CLB) begin
      if (FetchReq && LoadReq) begin
        cpu_gnt = ~last_cpu_q;
        ld_gnt  = last_cpu_q;
      end else begin
        cpu_gnt = FetchReq;
        ld_gnt  = LoadReq;
      end
    end
    if (cpu_gnt) begin
      last_cpu_d = 1'b1;
    end else if (ld_gnt) begin
      last_cpu_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge CLB) begin
    if (!CLB) begin
      last_cpu_q <= 1'b0;
    end else begin
      last_cpu_q <= last_cpu_d;
    end
  end
`else
  localparam int BW = $clog2(MAX_LOAD_BURST + 1);
  localparam logic [BW-1:0] MaxB = BW'(MAX_LOAD_BURST);

  logic [BW-1:0] burst_q, burst_d;

  always_comb begin
    cpu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    if (CLB) begin
      ld_gnt  = LoadReq && (!FetchReq || (burst_q != MaxB));
      cpu_gnt = FetchReq && !ld_gnt;
    end
  end

  // Counts loader grants that starved a pending fetch; saturates
  always_comb begin
    burst_d = burst_q;
    if (!FetchReq || cpu_gnt) begin
      burst_d = '0;
    end else if (ld_gnt && (burst_q != MaxB)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge CLB) begin
    if (!CLB) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`endif

  always_comb begin
    MemEn    = cpu_gnt | ld_gnt;
    MemWe    = ld_gnt & LoadWe;
    MemAddr  = '0;
    MemWData = '0;
    if (ld_gnt) begin
      MemAddr  = LoadAddr;
      MemWData = LoadWData;
    end else if (cpu_gnt) begin
      MemAddr = FetchAddr;
    end
    LoadGnt = ld_gnt;
    Stall   = CLB & FetchReq & ~cpu_gnt;
  end

  always_comb begin
    unique case (1'b1)
      (ld_gnt && LoadWe):  owner_d = s_LD_WR;
      (ld_gnt && !LoadWe): owner_d = s_LD_RD;
      cpu_gnt:             owner_d = s_CPU;
      default:             owner_d = s_NONE;
    endcase
  end

  // Return data is steered straight from memory in the valid cycle
  always_comb begin
    FetchValid   = (owner_q == s_CPU);
    FetchData    = FetchValid ? MemRData : fetch_data_q;
    fetch_data_d = FetchData;
    LoadValid    = (owner_q == s_LD_RD) || (owner_q == s_LD_WR);
    LoadRData    = load_rdata_q;
    if (owner_q == s_LD_RD) begin
      LoadRData = MemRData;
    end else if (owner_q == s_LD_WR) begin
      LoadRData = '0;
    end
    load_rdata_d = LoadRData;
  end

  always_ff @(posedge Clk or negedge CLB) begin
    if (!CLB) begin
      owner_q      <= s_NONE;
      fetch_data_q <= '0;
      load_rdata_q <= '0;
    end else begin
      owner_q      <= owner_d;
      fetch_data_q <= fetch_data_d;
      load_rdata_q <= load_rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter with an abstract cycle model.
// Honors IMEM_ARB_ROUND_ROBIN_EN when selecting the expected grant rule.
module tb_imem_port_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       CLB;
  logic       FetchReq;
  logic [7:0] FetchAddr;
  logic       FetchValid;
  logic [7:0] FetchData;
  logic       Stall;
  logic       LoadReq;
  logic       LoadWe;
  logic [7:0] LoadAddr;
  logic [7:0] LoadWData;
  logic       LoadGnt;
  logic       LoadValid;
  logic [7:0] LoadRData;
  logic       MemEn;
  logic       MemWe;
  logic [7:0] MemAddr;
  logic [7:0] MemWData;
  logic [7:0] MemRData = 8'h00;

  imem_port_arbiter #(
    .ADDR_W(8),
    .DATA_W(8),
    .MAX_LOAD_BURST(MAXB)
  ) dut (
    .Clk(clk),
    .CLB(CLB),
    .FetchReq(FetchReq),
    .FetchAddr(FetchAddr),
    .FetchValid(FetchValid),
    .FetchData(FetchData),
    .Stall(Stall),
    .LoadReq(LoadReq),
    .LoadWe(LoadWe),
    .LoadAddr(LoadAddr),
    .LoadWData(LoadWData),
    .LoadGnt(LoadGnt),
    .LoadValid(LoadValid),
    .LoadRData(LoadRData),
    .MemEn(MemEn),
    .MemWe(MemWe),
    .MemAddr(MemAddr),
    .MemWData(MemWData),
    .MemRData(MemRData)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (MemEn) begin
      if (MemWe) mem[MemAddr] <= MemWData;
      else MemRData <= mem[MemAddr];
    end
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [256];
  bit         e_fv, e_lv;
  logic [7:0] e_fd, e_ld;
  int         m_burst;
  bit         m_last_cpu;
  bit         was_cg, was_lg;
  bit         obs_gnt, obs_stall;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_fv = 0;
    e_lv = 0;
    e_fd = 8'h00;
    e_ld = 8'h00;
    m_burst = 0;
    m_last_cpu = 0;
    was_cg = 0;
    was_lg = 0;
  endtask

  task automatic step();
    bit cg, lg;
    @(negedge clk);
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    lg = LoadReq && (!FetchReq || m_last_cpu);
`else
    lg = LoadReq && (!FetchReq || m_burst != MAXB);
`endif
    cg = FetchReq && !lg;
    chk("mem_en", MemEn, cg | lg);
    chk("mem_we", MemWe, lg & LoadWe);
    chk("mem_addr", MemAddr, lg ? LoadAddr : (cg ? FetchAddr : 8'h00));
    chk("mem_wdata", MemWData, lg ? LoadWData : 8'h00);
    chk("load_gnt", LoadGnt, lg);
    chk("stall", Stall, FetchReq & !cg);
    chk("fetch_valid", FetchValid, e_fv);
    chk("fetch_data", FetchData, e_fd);
    chk("load_valid", LoadValid, e_lv);
    chk("load_rdata", LoadRData, e_ld);
    obs_gnt = LoadGnt;
    obs_stall = Stall;
    e_fv = cg;
    e_lv = lg;
    if (cg) e_fd = ref_mem[FetchAddr];
    if (lg && LoadWe) begin
      ref_mem[LoadAddr] = LoadWData;
      e_ld = 8'h00;
    end else if (lg) begin
      e_ld = ref_mem[LoadAddr];
    end
    if (!FetchReq || cg) m_burst = 0;
    else if (lg && m_burst < MAXB) m_burst++;
    if (cg) m_last_cpu = 1;
    else if (lg) m_last_cpu = 0;
    was_cg = cg;
    was_lg = lg;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    CLB = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    CLB = 1'b1;
  endtask

  initial begin
    logic [9:0] pat;
    int         nstall;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 8'h1D;
    ref_mem[5] = 8'h1D;

    CLB = 1'b0;
    FetchReq = 1'b1;
    FetchAddr = 8'h05;
    LoadReq = 1'b1;
    LoadWe = 1'b1;
    LoadAddr = 8'h33;
    LoadWData = 8'h5A;
    model_reset();
    #2;
    chk("rst_mem_en", MemEn, 0);
    chk("rst_mem_we", MemWe, 0);
    chk("rst_load_gnt", LoadGnt, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_fetch_valid", FetchValid, 0);
    chk("rst_fetch_data", FetchData, 0);
    chk("rst_load_valid", LoadValid, 0);
    chk("rst_load_rdata", LoadRData, 0);
    chk("rst_mem_wdata", MemWData, 0);
    @(posedge clk);
    #1;
    CLB = 1'b1;
    LoadReq = 1'b0;

    step();
    FetchReq = 1'b0;
    step();
    step();
    chk("cpu_fetch_hold", FetchData, 8'h1D);

    LoadReq = 1'b1;
    LoadWe = 1'b1;
    LoadAddr = 8'h10;
    LoadWData = 8'hA7;
    step();
    chk("ld_wr_ack_valid", LoadValid, 1);
    chk("ld_wr_ack_data", LoadRData, 0);
    LoadWe = 1'b0;
    step();
    chk("ld_rd_valid", LoadValid, 1);
    chk("ld_rd_data", LoadRData, 8'hA7);
    LoadReq = 1'b0;
    step();

    do_reset();
    FetchReq = 1'b1;
    FetchAddr = 8'h20;
    LoadReq = 1'b1;
    LoadWe = 1'b0;
    LoadAddr = 8'h21;
    pat = '0;
    nstall = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pat[i] = obs_gnt;
      if (obs_stall) nstall++;
    end
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    chk("contend_pattern", pat, 10'h2AA);
    chk("contend_stalls", nstall, 5);
`else
    chk("contend_pattern", pat, 10'h1EF);
    chk("contend_stalls", nstall, 8);
`endif

    FetchReq = 1'b0;
    LoadReq = 1'b0;
    step();
    for (int i = 0; i < 300; i++) begin
      if (!(FetchReq && !was_cg && $urandom_range(0, 9) != 0)) begin
        FetchReq = ($urandom_range(0, 2) != 0);
        FetchAddr = 8'($urandom);
      end
      if (!(LoadReq && !was_lg && $urandom_range(0, 9) != 0)) begin
        LoadReq = ($urandom_range(0, 2) != 0);
        LoadWe = 1'($urandom);
        LoadAddr = 8'($urandom_range(0, 15));
        LoadWData = 8'($urandom);
      end
      step();
    end

    do_reset();
    FetchReq = 1'b1;
    FetchAddr = 8'h05;
    LoadReq = 1'b0;
    step();
    CLB = 1'b0;
    #1;
    chk("midrst_fetch_valid", FetchValid, 0);
    chk("midrst_fetch_data", FetchData, 0);
    model_reset();
    @(posedge clk);
    #1;
    CLB = 1'b1;
    step();
    FetchReq = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
